// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: data width, FSM encodings.
`ifndef ALU_DEFS_SVH
`define ALU_DEFS_SVH

package alu_result_stage_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/alu_flags.sv
// Zero / negative flag generation for a 16-bit ALU result.
// zr is a 16-input NOR built from a gate primitive, in the same gate-level
// style as the rest of the ALU datapath; ng is simply the sign bit.
module alu_flags
  import alu_result_stage_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  output logic             zr,
  output logic             ng
);

  // Zero detect: NOR of every result bit.
  nor u_zr_nor (zr,
                a[0],  a[1],  a[2],  a[3],
                a[4],  a[5],  a[6],  a[7],
                a[8],  a[9],  a[10], a[11],
                a[12], a[13], a[14], a[15]);

  // Negative: two's-complement sign bit.
  assign ng = a[15];

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: captures each result with its
// zr/ng flags into a 2-entry FIFO (head, tail) with valid/ready toward the
// writeback consumer, and counts accepted results.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready and out_valid are decoded from the registered state
// only, so neither depends combinationally on in_valid or out_ready.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       fsm_state
);

  import alu_result_stage_pkg::*;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] head_data;
  logic             head_zr;
  logic             head_ng;
  logic [WIDTH-1:0] tail_data;
  logic             tail_zr;
  logic             tail_ng;

  logic             in_zr;
  logic             in_ng;
  logic             accept;
  logic             pop;

  // Flags are computed on the incoming result and stored with the entry.
  alu_flags u_flags (
    .a  (in_data),
    .zr (in_zr),
    .ng (in_ng)
  );

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = head_data;
  assign out_zr    = head_zr;
  assign out_ng    = head_ng;
  assign fsm_state = state;

  // Next occupancy from the accept/pop pair seen this cycle.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (accept) state_next = ONE;
      end
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (pop && !accept) state_next = EMPTY;
      end
      FULL: begin
        if (pop) state_next = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register; reset flushes the buffer regardless of handshakes.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Entry storage. Registers only load on an accept (or tail->head shift),
  // so in_data garbage while in_valid is low never reaches stored state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_data <= '0;
      head_zr   <= 1'b0;
      head_ng   <= 1'b0;
      tail_data <= '0;
      tail_zr   <= 1'b0;
      tail_ng   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_data <= in_data;
            head_zr   <= in_zr;
            head_ng   <= in_ng;
          end
        end
        ONE: begin
          if (accept && pop) begin
            // Old head leaves, the new result takes its place.
            head_data <= in_data;
            head_zr   <= in_zr;
            head_ng   <= in_ng;
          end else if (accept) begin
            tail_data <= in_data;
            tail_zr   <= in_zr;
            tail_ng   <= in_ng;
          end
        end
        FULL: begin
          if (pop) begin
            head_data <= tail_data;
            head_zr   <= tail_zr;
            head_ng   <= tail_ng;
          end
        end
        default: begin
          head_data <= head_data;
        end
      endcase
    end
  end

  // Accepted-result counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (accept) count <= count + 1'b1;
  end

endmodule
